// File: rtl/frame_scan_driver.sv
// ----------------------------------------------------------------------------
// frame_scan_driver
//
// Purpose:
//   Display-side initiator of the pixel-fetch interface. Walks the 256x64
//   frame one pixel byte at a time. For each byte it drives the address,
//   waits FETCH_LAT clocks, captures the returned byte, and shifts it out
//   MSB-first on an SPI-style LCD link. One frame is sent per accepted
//   frame_start.
//
// Optional feature (macro FRAME_CMD_EN):
//   When defined, each frame is preceded by three command bytes
//   (CMD0, CMD1, CMD2) sent with lcd_dc=0. When undefined there is no
//   header logic and lcd_dc is tied high.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   frame_start  request one frame, sampled only in IDLE
//   addrD[10:0]  pixel-byte address: [10:6] column group, [5:0] row
//   dataD[7:0]   pixel byte from the responder, bit7 = leftmost pixel
//   busy         high while a frame is in progress
//   frame_done   one-cycle pulse after the last byte
//   lcd_cs       chip select, active low
//   lcd_dc       1 = pixel data, 0 = command
//   lcd_sclk     serial clock, idle low, panel samples on rising edge
//   lcd_mosi     serial data
// ----------------------------------------------------------------------------
module frame_scan_driver #(
    parameter int         FETCH_LAT = 2,
    parameter int         SCLK_HALF = 1,
    parameter logic [7:0] CMD0      = 8'h00,
    parameter logic [7:0] CMD1      = 8'h10,
    parameter logic [7:0] CMD2      = 8'h40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    output logic [10:0] addrD,
    input  logic [7:0]  dataD,
    output logic        busy,
    output logic        frame_done,
    output logic        lcd_cs,
    output logic        lcd_dc,
    output logic        lcd_sclk,
    output logic        lcd_mosi
);

    localparam int LW = (FETCH_LAT > 1) ? $clog2(FETCH_LAT) : 1;
    localparam int HW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam logic [LW-1:0] LAT_LAST  = LW'(FETCH_LAT - 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(SCLK_HALF - 1);
    localparam logic [10:0]   ADDR_LAST = 11'd2047;

`ifdef FRAME_CMD_EN
    typedef enum logic [2:0] {IDLE, HDR, FETCH, SHIFT, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, FETCH, SHIFT, DONE} state_t;
`endif

    state_t          state_reg, state_next;
    logic [10:0]     addr_reg, addr_next;
    logic [LW-1:0]   lat_reg, lat_next;
    logic [HW-1:0]   half_reg, half_next;
    logic [2:0]      bit_reg, bit_next;
    logic [7:0]      shift_reg, shift_next;
    logic            sclk_reg, sclk_next;
    logic            mosi_reg, mosi_next;
    logic            cs_reg, cs_next;
    logic            busy_reg, busy_next;
    logic            done_reg, done_next;
    logic            serial_on;
    logic            byte_end;
`ifdef FRAME_CMD_EN
    logic            dc_reg, dc_next;
    logic [1:0]      hdr_reg, hdr_next;
`else
    logic [23:0]     cmd_unused;
    assign cmd_unused = {CMD0, CMD1, CMD2};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            lat_reg   <= '0;
            half_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            sclk_reg  <= 1'b0;
            mosi_reg  <= 1'b0;
            cs_reg    <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
`ifdef FRAME_CMD_EN
            dc_reg    <= 1'b1;
            hdr_reg   <= '0;
`endif
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            lat_reg   <= lat_next;
            half_reg  <= half_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            sclk_reg  <= sclk_next;
            mosi_reg  <= mosi_next;
            cs_reg    <= cs_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
`ifdef FRAME_CMD_EN
            dc_reg    <= dc_next;
            hdr_reg   <= hdr_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        lat_next   = lat_reg;
        half_next  = half_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        sclk_next  = sclk_reg;
        mosi_next  = mosi_reg;
        cs_next    = cs_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        byte_end   = 1'b0;
`ifdef FRAME_CMD_EN
        dc_next    = dc_reg;
        hdr_next   = hdr_reg;
        serial_on  = (state_reg == SHIFT) || (state_reg == HDR);
`else
        serial_on  = (state_reg == SHIFT);
`endif

        // Bit engine shared by pixel and header bytes: each bit is a low
        // phase then a high phase; mosi advances only as sclk falls.
        if (serial_on) begin
            if (half_reg != HALF_LAST) begin
                half_next = half_reg + 1'b1;
            end else begin
                half_next = '0;
                if (!sclk_reg) begin
                    sclk_next = 1'b1;
                end else if (bit_reg != 3'd7) begin
                    sclk_next  = 1'b0;
                    bit_next   = bit_reg + 3'd1;
                    shift_next = {shift_reg[6:0], 1'b0};
                    mosi_next  = shift_reg[6];
                end else begin
                    sclk_next = 1'b0;
                    bit_next  = '0;
                    byte_end  = 1'b1;
                end
            end
        end

        case (state_reg)
            IDLE: begin
                if (frame_start) begin
                    busy_next = 1'b1;
                    cs_next   = 1'b0;
                    addr_next = '0;
                    sclk_next = 1'b0;
                    half_next = '0;
                    bit_next  = '0;
`ifdef FRAME_CMD_EN
                    state_next = HDR;
                    dc_next    = 1'b0;
                    hdr_next   = '0;
                    shift_next = CMD0;
                    mosi_next  = CMD0[7];
`else
                    state_next = FETCH;
                    lat_next   = '0;
`endif
                end
            end
`ifdef FRAME_CMD_EN
            HDR: begin
                if (byte_end) begin
                    if (hdr_reg == 2'd2) begin
                        dc_next    = 1'b1;
                        state_next = FETCH;
                        addr_next  = '0;
                        lat_next   = '0;
                    end else begin
                        hdr_next   = hdr_reg + 2'd1;
                        shift_next = (hdr_reg == 2'd0) ? CMD1 : CMD2;
                        mosi_next  = (hdr_reg == 2'd0) ? CMD1[7] : CMD2[7];
                    end
                end
            end
`endif
            FETCH: begin
                // Address has been stable FETCH_LAT clocks: capture now.
                if (lat_reg == LAT_LAST) begin
                    shift_next = dataD;
                    mosi_next  = dataD[7];
                    sclk_next  = 1'b0;
                    half_next  = '0;
                    bit_next   = '0;
                    state_next = SHIFT;
                end else begin
                    lat_next = lat_reg + 1'b1;
                end
            end
            SHIFT: begin
                if (byte_end) begin
                    if (addr_reg == ADDR_LAST) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                        busy_next  = 1'b0;
                        cs_next    = 1'b1;
                        addr_next  = '0;
                    end else begin
                        // Row in [5:0] runs fastest; its carry moves to the
                        // next column group in [10:6].
                        addr_next  = addr_reg + 11'd1;
                        lat_next   = '0;
                        state_next = FETCH;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign addrD      = addr_reg;
    assign busy       = busy_reg;
    assign frame_done = done_reg;
    assign lcd_cs     = cs_reg;
    assign lcd_sclk   = sclk_reg;
    assign lcd_mosi   = mosi_reg;
`ifdef FRAME_CMD_EN
    assign lcd_dc     = dc_reg;
`else
    assign lcd_dc     = 1'b1;
`endif

endmodule

// File: tb/tb_frame_scan_driver.sv
// ----------------------------------------------------------------------------
// tb_frame_scan_driver
//
// Directed bench for frame_scan_driver with default parameters. A responder
// returns addr[7:0] (8'hA5 for address 0 when a5_mode is set); a panel model
// collects bytes from the LCD link. Honours FRAME_CMD_EN for the header.
// ----------------------------------------------------------------------------
module tb_frame_scan_driver;

`ifdef FRAME_CMD_EN
    localparam int HDR_BYTES = 3;
    localparam int HDR_CLKS  = 48;
`else
    localparam int HDR_BYTES = 0;
    localparam int HDR_CLKS  = 0;
`endif
    localparam int BYTE_CLKS  = 18;
    localparam int FRAME_CLKS = 36864 + HDR_CLKS;

    logic        clk;
    logic        rst;
    logic        frame_start;
    logic [10:0] addrD;
    logic [7:0]  dataD;
    logic        busy;
    logic        frame_done;
    logic        lcd_cs;
    logic        lcd_dc;
    logic        lcd_sclk;
    logic        lcd_mosi;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit a5_mode;
    bit mon_clear;

    frame_scan_driver dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .addrD       (addrD),
        .dataD       (dataD),
        .busy        (busy),
        .frame_done  (frame_done),
        .lcd_cs      (lcd_cs),
        .lcd_dc      (lcd_dc),
        .lcd_sclk    (lcd_sclk),
        .lcd_mosi    (lcd_mosi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb dataD = (a5_mode && addrD == 11'd0) ? 8'hA5 : addrD[7:0];

    // Panel and scan monitor, sampled on the falling clock edge.
    logic [7:0]  pacc;
    int          pbit;
    logic [7:0]  bytes_q[$];
    bit          dcs_q[$];
    bit          prev_sclk;
    bit          prev_mosi;
    logic [10:0] prev_addr;
    int          mosi_err;
    int          addr_err;
    int          addr_steps;
    int          done_cnt;
    bit          wrap_seen;

    always @(negedge clk) begin
        if (mon_clear) begin
            bytes_q.delete();
            dcs_q.delete();
            mosi_err   = 0;
            addr_err   = 0;
            addr_steps = 0;
            done_cnt   = 0;
            wrap_seen  = 0;
        end
        if (lcd_cs) begin
            pbit = 0;
            pacc = 8'h00;
        end else if (!prev_sclk && lcd_sclk) begin
            pacc = {pacc[6:0], lcd_mosi};
            pbit = pbit + 1;
            if (pbit == 8) begin
                bytes_q.push_back(pacc);
                dcs_q.push_back(lcd_dc);
                pbit = 0;
            end
        end
        if (prev_sclk && lcd_sclk && (lcd_mosi != prev_mosi)) mosi_err = mosi_err + 1;
        if (busy && addrD != prev_addr) begin
            if (addrD != prev_addr + 11'd1) addr_err = addr_err + 1;
            if (prev_addr == 11'd63 && addrD == 11'd64) wrap_seen = 1;
            addr_steps = addr_steps + 1;
        end
        if (frame_done) done_cnt = done_cnt + 1;
        prev_sclk = lcd_sclk;
        prev_mosi = lcd_mosi;
        prev_addr = addrD;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cs"},   32'(lcd_cs),     32'd1);
        check({tag, "_dc"},   32'(lcd_dc),     32'd1);
        check({tag, "_sclk"}, 32'(lcd_sclk),   32'd0);
        check({tag, "_mosi"}, 32'(lcd_mosi),   32'd0);
        check({tag, "_busy"}, 32'(busy),       32'd0);
        check({tag, "_done"}, 32'(frame_done), 32'd0);
        check({tag, "_addr"}, 32'(addrD),      32'd0);
    endtask

    initial begin
        int n;
        int t0;
        int bad;
        int dbad;
        logic [7:0] exp_b;
        logic [7:0] hdr_exp [3];
        hdr_exp[0] = 8'h00;
        hdr_exp[1] = 8'h10;
        hdr_exp[2] = 8'h40;

        rst = 1'b1;
        frame_start = 1'b0;
        a5_mode = 1'b0;
        mon_clear = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check_reset("rst");
        rst = 1'b0;
        mon_clear = 1'b0;
        $display("reset applied and released");

        // Idle with no request: nothing moves.
        bad = 0;
        repeat (100) begin
            @(negedge clk); #2;
            if (lcd_cs !== 1'b1 || lcd_sclk !== 1'b0 || busy !== 1'b0 || addrD !== 11'd0) bad++;
        end
        check("idle_hold", bad, 0);
        $display("idle hold: %0d bad cycles", bad);

        // Frame A: aborted by reset at byte 700, bit 3.
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        check("a_start_busy", 32'(busy), 32'd1);
        check("a_start_cs", 32'(lcd_cs), 32'd0);
        check("a_start_addr", 32'(addrD), 32'd0);
        check("a_start_dc", 32'(lcd_dc), HDR_BYTES > 0 ? 32'd0 : 32'd1);
        repeat (50) @(negedge clk);
        #2;
        frame_start = 1'b1;     // must be ignored while busy
        repeat (5) @(negedge clk);
        #2;
        frame_start = 1'b0;
        n = 0;
        while (!(addrD == 11'd700 && pbit == 3) && n < 20000) begin
            @(negedge clk); #2;
            n++;
        end
        check("a_reach_byte700", 32'(n < 20000), 32'd1);
        check("a_addr_order", addr_err, 0);
        check("a_mosi_stable", mosi_err, 0);
        rst = 1'b1;
        #1;
        check_reset("midrst");
        @(negedge clk); #2;
        rst = 1'b0;
        @(negedge clk); #2;
        check("midrst_idle_busy", 32'(busy), 32'd0);
        $display("frame A aborted at addr 700 after %0d waits", n);

        // Frame B: full frame with frame_start held high throughout.
        mon_clear = 1'b1;
        a5_mode = 1'b1;
        @(negedge clk); #2;
        mon_clear = 1'b0;
        frame_start = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        check("b_start_busy", 32'(busy), 32'd1);
        check("b_start_addr", 32'(addrD), 32'd0);
        n = 0;
        while (addrD != 11'd1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("b_first_byte_clks", cyc - t0, BYTE_CLKS + HDR_CLKS);
        $display("frame B first byte done after %0d clocks", cyc - t0);
        n = 0;
        while (frame_done !== 1'b1 && n < 40000) begin
            @(posedge clk); #1;
            n++;
        end
        check("b_frame_clks", cyc - t0, FRAME_CLKS);
        check("b_done_busy", 32'(busy), 32'd0);
        check("b_done_cs", 32'(lcd_cs), 32'd1);
        check("b_done_addr", 32'(addrD), 32'd0);
        $display("frame B done after %0d clocks", cyc - t0);
        @(posedge clk); #1;
        check("b_done_pulse_end", 32'(frame_done), 32'd0);
        check("b_idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("c_restart_busy", 32'(busy), 32'd1);
        check("c_restart_addr", 32'(addrD), 32'd0);
        frame_start = 1'b0;
        @(negedge clk); #2;

        check("b_byte_count", bytes_q.size(), 2048 + HDR_BYTES);
        bad = 0;
        dbad = 0;
        for (int i = 0; i < bytes_q.size() && i < 2048 + HDR_BYTES; i++) begin
            if (i < HDR_BYTES) begin
                exp_b = hdr_exp[i];
                if (dcs_q[i] != 1'b0) dbad++;
            end else begin
                exp_b = (i == HDR_BYTES) ? 8'hA5 : 8'(i - HDR_BYTES);
                if (dcs_q[i] != 1'b1) dbad++;
            end
            if (bytes_q[i] !== exp_b) bad++;
        end
        if (bytes_q.size() > HDR_BYTES) check("b_first_pixel", 32'(bytes_q[HDR_BYTES]), 32'hA5);
        else check("b_first_pixel", 32'hFFFF_FFFF, 32'hA5);
        check("b_pixel_data", bad, 0);
        check("b_dc_bits", dbad, 0);
        check("b_addr_steps", addr_steps, 2047);
        check("b_addr_order", addr_err, 0);
        check("b_row_wrap", 32'(wrap_seen), 32'd1);
        check("b_mosi_stable", mosi_err, 0);
        check("b_done_count", done_cnt, 1);
        $display("frame B panel: %0d bytes, %0d data errors", bytes_q.size(), bad);

        // Frame C was started by the held request; stop it with reset.
        repeat (40) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset("c_rst");
        @(negedge clk); #2;
        rst = 1'b0;
        $display("frame C stopped by reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
